// File: rtl/pipe_stall_ctrl.sv
// Hazard/stall controller: load-use stalls, multi-cycle EX sequencing, forwarding.
// Optional STALL_CNT_EN adds a saturating stall-cycle counter output.
module pipe_stall_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MC_TIMEOUT = 64
`ifdef STALL_CNT_EN
  ,parameter int CNT_W     = 32
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs2,
  input  logic                  ex_valid,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_is_load,
  input  logic                  ex_is_mc,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  input  logic                  mc_done,
  output logic                  mc_start,
  output logic                  pc_hold,
  output logic                  ifid_hold,
  output logic                  idex_hold,
  output logic                  idex_bubble,
  output logic                  exmem_bubble,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  mc_timeout
`ifdef STALL_CNT_EN
  ,output logic [CNT_W-1:0]     stall_cnt
`endif
);

  localparam int TW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(MC_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    MC_WAIT,
    FAULT
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] cnt, cnt_n;
  logic          tmo_n;
  logic          ld_use;
  logic          rs2_hit;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] rs
  );
    if (mem_reg_write && mem_rd != '0 && mem_rd == rs)
      return 2'b01;
    else if (wb_reg_write && wb_rd != '0 && wb_rd == rs)
      return 2'b10;
    else
      return 2'b00;
  endfunction

  // Operand forwarding; x0 never forwards, EX/MEM has priority.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (reset) begin
      fwd_a = fwd_sel(ex_rs1);
      fwd_b = fwd_sel(ex_rs2);
    end
  end

  assign rs2_hit = id_uses_rs2 && ex_rd == id_rs2;
  assign ld_use  = ex_valid && ex_is_load && ex_reg_write &&
                   ex_rd != '0 && id_valid &&
                   (ex_rd == id_rs1 || rs2_hit);

  // State, timeout counter and sticky fault flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      mc_timeout <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      mc_timeout <= tmo_n;
    end
  end

  // Next state and hold/bubble/start controls.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    tmo_n        = mc_timeout;
    mc_start     = 1'b0;
    pc_hold      = 1'b0;
    ifid_hold    = 1'b0;
    idex_hold    = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    if (reset) begin
      unique case (state)
        IDLE: begin
          if (ex_valid && ex_is_mc) begin
            mc_start     = 1'b1;
            pc_hold      = 1'b1;
            ifid_hold    = 1'b1;
            idex_hold    = 1'b1;
            exmem_bubble = 1'b1;
            cnt_n        = '0;
            state_n      = MC_WAIT;
          end else if (ld_use) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_bubble = 1'b1;
          end
        end
        MC_WAIT: begin
          if (mc_done) begin
            state_n = IDLE;
          end else begin
            pc_hold      = 1'b1;
            ifid_hold    = 1'b1;
            idex_hold    = 1'b1;
            exmem_bubble = 1'b1;
            if (cnt == TLAST) begin
              state_n = FAULT;
              tmo_n   = 1'b1;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
        end
        FAULT: begin
          pc_hold      = 1'b1;
          ifid_hold    = 1'b1;
          idex_hold    = 1'b1;
          exmem_bubble = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

`ifdef STALL_CNT_EN
  // Saturating count of cycles with the PC held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cnt <= '0;
    else if (pc_hold && stall_cnt != '1)
      stall_cnt <= stall_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Randomized + directed bench for pipe_stall_ctrl.
// Reference model tracks busy/fault mode and waited cycles.
module tb_pipe_stall_ctrl;
  localparam int RAW = 5;
  localparam int MCT = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           id_valid, id_uses_rs2;
  logic [RAW-1:0] id_rs1, id_rs2;
  logic           ex_valid, ex_reg_write;
  logic           ex_is_load, ex_is_mc;
  logic [RAW-1:0] ex_rs1, ex_rs2, ex_rd;
  logic [RAW-1:0] mem_rd, wb_rd;
  logic           mem_reg_write, wb_reg_write;
  logic           mc_done;
  logic           mc_start, pc_hold, ifid_hold;
  logic           idex_hold, idex_bubble;
  logic           exmem_bubble, mc_timeout;
  logic [1:0]     fwd_a, fwd_b;
`ifdef STALL_CNT_EN
  logic [31:0]    stall_cnt;
`endif

  int tests = 0;
  int fails = 0;

  bit          m_busy, m_fault, m_tmo;
  int          m_wait;
  logic [31:0] m_scnt;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(
    .REG_ADDR_W(RAW),
    .MC_TIMEOUT(MCT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .id_valid(id_valid),
    .id_rs1(id_rs1),
    .id_rs2(id_rs2),
    .id_uses_rs2(id_uses_rs2),
    .ex_valid(ex_valid),
    .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2),
    .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write),
    .ex_is_load(ex_is_load),
    .ex_is_mc(ex_is_mc),
    .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write),
    .mc_done(mc_done),
    .mc_start(mc_start),
    .pc_hold(pc_hold),
    .ifid_hold(ifid_hold),
    .idex_hold(idex_hold),
    .idex_bubble(idex_bubble),
    .exmem_bubble(exmem_bubble),
    .fwd_a(fwd_a),
    .fwd_b(fwd_b),
    .mc_timeout(mc_timeout)
`ifdef STALL_CNT_EN
    ,.stall_cnt(stall_cnt)
`endif
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_busy  = 0;
    m_fault = 0;
    m_tmo   = 0;
    m_wait  = 0;
    m_scnt  = '0;
  endtask

  function automatic logic [1:0] exp_fwd(
    input logic [RAW-1:0] rs
  );
    if (mem_reg_write && mem_rd != 0 && mem_rd == rs)
      return 2'd1;
    if (wb_reg_write && wb_rd != 0 && wb_rd == rs)
      return 2'd2;
    return 2'd0;
  endfunction

  task automatic clear_in();
    id_valid = 0; id_uses_rs2 = 0;
    id_rs1 = 0; id_rs2 = 0;
    ex_valid = 0; ex_reg_write = 0;
    ex_is_load = 0; ex_is_mc = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
    mem_rd = 0; wb_rd = 0;
    mem_reg_write = 0; wb_reg_write = 0;
    mc_done = 0;
  endtask

  task automatic rand_in();
    id_valid      = 1'($urandom_range(0, 3) != 0);
    id_uses_rs2   = 1'($urandom);
    id_rs1        = RAW'($urandom_range(0, 3));
    id_rs2        = RAW'($urandom_range(0, 3));
    ex_valid      = 1'($urandom_range(0, 3) != 0);
    ex_reg_write  = 1'($urandom_range(0, 3) != 0);
    ex_is_load    = 1'($urandom);
    ex_is_mc      = 1'($urandom_range(0, 9) == 0);
    ex_rs1        = RAW'($urandom_range(0, 3));
    ex_rs2        = RAW'($urandom_range(0, 3));
    ex_rd         = RAW'($urandom_range(0, 3));
    mem_rd        = RAW'($urandom_range(0, 3));
    wb_rd         = RAW'($urandom_range(0, 3));
    mem_reg_write = 1'($urandom);
    wb_reg_write  = 1'($urandom);
    mc_done       = 1'($urandom_range(0, 4) == 0);
  endtask

  // Check every output against the model, then advance one clock.
  task automatic tick();
    bit e_st, e_pc, e_if, e_ih, e_ib, e_xb, lu;
    logic [1:0] ea, eb;
    #1;
    if (!reset) model_clear();
    e_st = 0; e_pc = 0; e_if = 0;
    e_ih = 0; e_ib = 0; e_xb = 0;
    ea = 0; eb = 0;
    lu = ex_valid && ex_is_load && ex_reg_write &&
         ex_rd != 0 && id_valid &&
         (ex_rd == id_rs1 ||
          (id_uses_rs2 && ex_rd == id_rs2));
    if (reset) begin
      ea = exp_fwd(ex_rs1);
      eb = exp_fwd(ex_rs2);
      if (m_fault || (m_busy && !mc_done)) begin
        e_pc = 1; e_if = 1; e_ih = 1; e_xb = 1;
      end else if (!m_busy && ex_valid && ex_is_mc) begin
        e_st = 1; e_pc = 1; e_if = 1;
        e_ih = 1; e_xb = 1;
      end else if (!m_busy && lu) begin
        e_pc = 1; e_if = 1; e_ib = 1;
      end
    end
    chk("mc_start", 32'(mc_start), 32'(e_st));
    chk("pc_hold", 32'(pc_hold), 32'(e_pc));
    chk("ifid_hold", 32'(ifid_hold), 32'(e_if));
    chk("idex_hold", 32'(idex_hold), 32'(e_ih));
    chk("idex_bubble", 32'(idex_bubble), 32'(e_ib));
    chk("exmem_bubble", 32'(exmem_bubble), 32'(e_xb));
    chk("fwd_a", 32'(fwd_a), 32'(ea));
    chk("fwd_b", 32'(fwd_b), 32'(eb));
    chk("mc_timeout", 32'(mc_timeout), 32'(m_tmo));
`ifdef STALL_CNT_EN
    chk("stall_cnt", stall_cnt, m_scnt);
`endif
    @(posedge clk);
    if (!reset) begin
      model_clear();
    end else begin
      if (e_pc && m_scnt != 32'hFFFF_FFFF) m_scnt++;
      if (m_fault) begin
      end else if (m_busy) begin
        if (mc_done) begin
          m_busy = 0;
        end else begin
          m_wait++;
          if (m_wait == MCT) begin
            m_fault = 1;
            m_busy  = 0;
            m_tmo   = 1;
          end
        end
      end else if (ex_valid && ex_is_mc) begin
        m_busy = 1;
        m_wait = 0;
      end
    end
    #1;
  endtask

  initial begin
    model_clear();
    clear_in();
    reset = 0;
    rand_in();
    tick();
    tick();
    clear_in();
    reset = 1;
    tick();

    // Load-use on x5 through rs1.
    ex_valid = 1; ex_is_load = 1;
    ex_reg_write = 1; ex_rd = 5;
    id_valid = 1; id_rs1 = 5;
    #1;
    chk("lu_pc_hold", 32'(pc_hold), 32'd1);
    chk("lu_idex_bubble", 32'(idex_bubble), 32'd1);
    tick();
    clear_in();
    tick();

    // Load to x0 never stalls; EX/MEM beats MEM/WB.
    ex_valid = 1; ex_is_load = 1;
    ex_reg_write = 1; ex_rd = 0;
    id_valid = 1; id_rs1 = 0;
    mem_rd = 3; mem_reg_write = 1;
    wb_rd = 3; wb_reg_write = 1;
    ex_rs1 = 3;
    #1;
    chk("x0_pc_hold", 32'(pc_hold), 32'd0);
    chk("fwd_a_prio", 32'(fwd_a), 32'd1);
    tick();
    clear_in();

    // Multi-cycle op, done on the fourth wait cycle.
    ex_valid = 1; ex_is_mc = 1;
    tick();
    clear_in();
    for (int i = 0; i < 4; i++) begin
      mc_done = (i == 3);
      tick();
    end
    clear_in();
    mc_done = 1;
    tick();
    clear_in();

    // Reset mid-wait aborts, stale done ignored.
    ex_valid = 1; ex_is_mc = 1;
    tick();
    clear_in();
    tick();
    reset = 0;
    tick();
    reset = 1;
    mc_done = 1;
    tick();
    clear_in();

    // Timeout into fault.
    ex_valid = 1; ex_is_mc = 1;
    tick();
    clear_in();
    for (int i = 0; i < MCT + 3; i++) tick();
    #1;
    chk("fault_flag", 32'(mc_timeout), 32'd1);
    chk("fault_hold", 32'(pc_hold), 32'd1);
    reset = 0;
    tick();
    reset = 1;

    // Random traffic with occasional resets.
    for (int n = 0; n < 4000; n++) begin
      rand_in();
      reset = ($urandom_range(0, 79) != 0);
      tick();
    end
    reset = 1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
